// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bus bit positions and the MEM-stage FSM encoding.
package mips_pkg;
    localparam int MC_BRANCH   = 2;
    localparam int MC_READ     = 1;
    localparam int MC_WRITE    = 0;
    localparam int WC_REGWRITE = 1;
    localparam int WC_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;
endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-organised data memory: asynchronous read, single-port synchronous write.
module data_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, wait-stated data memory access with front-end stall,
// misalignment detection and the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_mem_data2,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_alu_res,
    input  logic        ex_mem_zero,
    input  logic [31:0] ex_mem_pc_4_off,
    input  logic [2:0]  ex_mem_mem_con,
    input  logic [1:0]  ex_mem_wr_con,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_stall,
    output logic [1:0]  mem_wb_wr_con,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_res,
    output logic        mis_align
);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_e  state;
    logic [3:0]  cnt;
    logic        rd_en, wr_en, pending, misaligned, we;
    logic [31:0] rdata;

    assign rd_en         = ex_mem_mem_con[MC_READ];
    assign wr_en         = ex_mem_mem_con[MC_WRITE];
    assign pending       = rd_en | wr_en;
    assign misaligned    = pending && (ex_mem_alu_res[1:0] != 2'b00);
    assign pc_src        = ex_mem_mem_con[MC_BRANCH] & ex_mem_zero;
    assign branch_target = ex_mem_pc_4_off;

    always_comb begin
        mem_stall = 1'b0;
        if (rst_n) begin
            if (state == BUSY) mem_stall = (cnt != 4'd0);
            else               mem_stall = pending && (WAIT_STATES != 0);
        end
    end

    // Store commits only on the completing cycle, so it lands exactly once.
    assign we = rst_n && !mem_stall && wr_en && !misaligned;

    data_mem #(.ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (ex_mem_alu_res[ADDR_W+1:2]),
        .wdata (ex_mem_data2),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (pending && WAIT_STATES != 0) begin
                    state <= BUSY;
                    cnt   <= CNT_INIT;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                      else             state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_wr_con    <= 2'b00;
            mem_wb_rd        <= 5'd0;
            mem_wb_read_data <= 32'd0;
            mem_wb_alu_res   <= 32'd0;
            mis_align        <= 1'b0;
        end else begin
            mis_align <= mis_align | misaligned;
            if (mem_stall) begin
                // Bubble so write-back never retires the stalled instruction twice.
                mem_wb_wr_con    <= 2'b00;
                mem_wb_rd        <= 5'd0;
                mem_wb_read_data <= 32'd0;
                mem_wb_alu_res   <= 32'd0;
            end else begin
                mem_wb_wr_con    <= ex_mem_wr_con;
                mem_wb_rd        <= ex_mem_rd;
                mem_wb_read_data <= (rd_en && !misaligned) ? rdata : 32'd0;
                mem_wb_alu_res   <= ex_mem_alu_res;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: wait-stated instance (WAIT_STATES=2) and single-cycle instance.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // WAIT_STATES=2 instance
    logic [31:0] data2, alu_res, pc_4_off;
    logic [4:0]  rd;
    logic        zero;
    logic [2:0]  mem_con;
    logic [1:0]  wr_con;
    logic        pc_src, mem_stall, mis_align;
    logic [31:0] branch_target, wb_read_data, wb_alu_res;
    logic [1:0]  wb_wr_con;
    logic [4:0]  wb_rd;

    // WAIT_STATES=0 instance
    logic [31:0] z_data2, z_alu_res;
    logic [4:0]  z_rd;
    logic [2:0]  z_mem_con;
    logic [1:0]  z_wr_con;
    logic        z_pc_src, z_mem_stall, z_mis_align;
    logic [31:0] z_branch_target, z_wb_read_data, z_wb_alu_res;
    logic [1:0]  z_wb_wr_con;
    logic [4:0]  z_wb_rd;

    mem_stage #(.ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_data2(data2), .ex_mem_rd(rd), .ex_mem_alu_res(alu_res),
        .ex_mem_zero(zero), .ex_mem_pc_4_off(pc_4_off),
        .ex_mem_mem_con(mem_con), .ex_mem_wr_con(wr_con),
        .pc_src(pc_src), .branch_target(branch_target), .mem_stall(mem_stall),
        .mem_wb_wr_con(wb_wr_con), .mem_wb_rd(wb_rd),
        .mem_wb_read_data(wb_read_data), .mem_wb_alu_res(wb_alu_res),
        .mis_align(mis_align)
    );

    mem_stage #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_data2(z_data2), .ex_mem_rd(z_rd), .ex_mem_alu_res(z_alu_res),
        .ex_mem_zero(1'b0), .ex_mem_pc_4_off(32'd0),
        .ex_mem_mem_con(z_mem_con), .ex_mem_wr_con(z_wr_con),
        .pc_src(z_pc_src), .branch_target(z_branch_target), .mem_stall(z_mem_stall),
        .mem_wb_wr_con(z_wb_wr_con), .mem_wb_rd(z_wb_rd),
        .mem_wb_read_data(z_wb_read_data), .mem_wb_alu_res(z_wb_alu_res),
        .mis_align(z_mis_align)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] mc, input logic [1:0] wc, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d, input logic z,
                         input logic [31:0] pc);
        mem_con = mc; wr_con = wc; rd = r; alu_res = a; data2 = d; zero = z; pc_4_off = pc;
    endtask

    // Runs one access on the wait-stated instance: checks stall on each MEM cycle and
    // the bubbles written on stalled edges; returns just after the completing edge.
    task automatic run_access(input string tag, input int ws);
        for (int i = 0; i <= ws; i++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(mem_stall), 32'(i < ws));
            if (i > 0) chk({tag, "_bubble"}, 32'(wb_wr_con), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic z_step(input logic [2:0] mc, input logic [1:0] wc, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input string tag);
        z_mem_con = mc; z_wr_con = wc; z_rd = r; z_alu_res = a; z_data2 = d;
        @(negedge clk);
        chk({tag, "_stall"}, 32'(z_mem_stall), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_wrcon"}, 32'(z_wb_wr_con), 32'(wc));
        chk({tag, "_rd"}, 32'(z_wb_rd), 32'(r));
        chk({tag, "_alu"}, z_wb_alu_res, a);
        chk({tag, "_data"}, z_wb_read_data, exp_data);
    endtask

    initial begin
        drive(3'b000, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        z_mem_con = 3'b000; z_wr_con = 2'b00; z_rd = 5'd0; z_alu_res = 32'd0; z_data2 = 32'd0;

        // Reset state
        #12;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wrcon", 32'(wb_wr_con), 32'd0);
        chk("rst_data", wb_read_data, 32'd0);
        chk("rst_mis", 32'(mis_align), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SW 0xDEADBEEF to word 4
        drive(3'b001, 2'b00, 5'd0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        run_access("sw4", 2);
        chk("sw4_wrcon", 32'(wb_wr_con), 32'd0);
        chk("sw4_alu", wb_alu_res, 32'h10);
        chk("sw4_data", wb_read_data, 32'd0);

        // LW from word 4
        drive(3'b010, 2'b11, 5'd8, 32'h10, 32'd0, 1'b0, 32'd0);
        run_access("lw4", 2);
        chk("lw4_data", wb_read_data, 32'hDEADBEEF);
        chk("lw4_rd", 32'(wb_rd), 32'd8);
        chk("lw4_wrcon", 32'(wb_wr_con), 32'd3);

        // Branch taken resolves same cycle without stalling
        drive(3'b100, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 32'h40);
        @(negedge clk);
        chk("br_pcsrc", 32'(pc_src), 32'd1);
        chk("br_target", branch_target, 32'h40);
        chk("br_stall", 32'(mem_stall), 32'd0);
        zero = 1'b0; #1;
        chk("br_nottaken", 32'(pc_src), 32'd0);
        @(posedge clk); #1;

        // Misaligned LW keeps normal latency, returns 0, sets sticky flag
        drive(3'b010, 2'b11, 5'd9, 32'h13, 32'd0, 1'b0, 32'd0);
        run_access("lwmis", 2);
        chk("lwmis_data", wb_read_data, 32'd0);
        chk("lwmis_flag", 32'(mis_align), 32'd1);
        chk("lwmis_rd", 32'(wb_rd), 32'd9);
        drive(3'b010, 2'b11, 5'd10, 32'h10, 32'd0, 1'b0, 32'd0);
        run_access("lwok", 2);
        chk("lwok_data", wb_read_data, 32'hDEADBEEF);
        chk("lwok_sticky", 32'(mis_align), 32'd1);

        // Wrap: byte address 0x410 aliases word 4 with ADDR_W=8
        drive(3'b010, 2'b11, 5'd11, 32'h410, 32'd0, 1'b0, 32'd0);
        run_access("lwwrap", 2);
        chk("lwwrap_data", wb_read_data, 32'hDEADBEEF);

        // Seed word 5, then reset in the second stall cycle of an overwriting SW
        drive(3'b001, 2'b00, 5'd0, 32'h14, 32'h11111111, 1'b0, 32'd0);
        run_access("sw5", 2);
        drive(3'b001, 2'b00, 5'd0, 32'h14, 32'h55555555, 1'b0, 32'd0);
        @(negedge clk);
        chk("sw5b_stall1", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sw5b_stall2", 32'(mem_stall), 32'd1);
        rst_n = 1'b0; #1;
        chk("midrst_stall", 32'(mem_stall), 32'd0);
        chk("midrst_wrcon", 32'(wb_wr_con), 32'd0);
        chk("midrst_alu", wb_alu_res, 32'd0);
        chk("midrst_mis", 32'(mis_align), 32'd0);
        @(posedge clk); #1;
        drive(3'b000, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        drive(3'b010, 2'b11, 5'd12, 32'h14, 32'd0, 1'b0, 32'd0);
        run_access("lw5", 2);
        chk("lw5_data", wb_read_data, 32'h11111111);

        // Read+write together: load sees pre-store word, store commits
        drive(3'b011, 2'b11, 5'd13, 32'h10, 32'hA5A5A5A5, 1'b0, 32'd0);
        run_access("rw4", 2);
        chk("rw4_old", wb_read_data, 32'hDEADBEEF);
        drive(3'b010, 2'b11, 5'd14, 32'h10, 32'd0, 1'b0, 32'd0);
        run_access("rw4chk", 2);
        chk("rw4_new", wb_read_data, 32'hA5A5A5A5);
        drive(3'b000, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Single-cycle instance: alternating SW/LW/ALU, one result per cycle
        z_step(3'b001, 2'b00, 5'd0, 32'h20, 32'hCAFEF00D, 32'd0,        "z_sw");
        z_step(3'b010, 2'b11, 5'd3, 32'h20, 32'd0,        32'hCAFEF00D, "z_lw");
        z_step(3'b000, 2'b10, 5'd4, 32'h1234, 32'd0,      32'd0,        "z_alu");
        z_step(3'b001, 2'b00, 5'd0, 32'h24, 32'h0BADF00D, 32'd0,        "z_sw2");
        z_step(3'b010, 2'b11, 5'd5, 32'h24, 32'd0,        32'h0BADF00D, "z_lw2");
        chk("z_mis", 32'(z_mis_align), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register. It consumes the EX/MEM fields, resolves branches, and accesses a word-organised data memory with configurable wait states. It stalls the front of the pipeline while an access is in flight and drives the MEM/WB pipeline register outputs consumed by write-back.

## Interface
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- WAIT_STATES, 2, extra cycles per load/store (0..15); 0 means a single-cycle access.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_mem_data2  in  32  store data (rt).
- ex_mem_rd  in  5  destination register.
- ex_mem_alu_res  in  32  byte address, or pass-through ALU result.
- ex_mem_zero  in  1  ALU zero flag.
- ex_mem_pc_4_off  in  32  branch target.
- ex_mem_mem_con  in  3  [2] branch, [1] mem_read, [0] mem_write.
- ex_mem_wr_con  in  2  [1] reg_write, [0] mem_to_reg.
- pc_src  out  1  take branch; combinational.
- branch_target  out  32  equals ex_mem_pc_4_off; combinational.
- mem_stall  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers this cycle; combinational.
- mem_wb_wr_con  out  2  registered wr_con; 2'b00 is a bubble.
- mem_wb_rd  out  5  registered rd.
- mem_wb_read_data  out  32  registered load data.
- mem_wb_alu_res  out  32  registered ALU result.
- mis_align  out  1  sticky misaligned-access flag.

## Operation
- An access is pending when mem_read or mem_write is set. Upstream holds every ex_mem_* input stable while mem_stall=1.
- Branch resolution:
  - pc_src = mem_con[2] & ex_mem_zero.
  - Branches never stall.
- Memory address decoding:
  - Word index = alu_res[ADDR_W+1:2].
  - Address bits above ADDR_W+1 are ignored, so accesses wrap modulo the memory depth.
- FSM states:
  - IDLE, BUSY.
  - IDLE with a pending access and WAIT_STATES>0: mem_stall=1, load cnt=WAIT_STATES-1, go to BUSY.
  - BUSY with cnt!=0: mem_stall=1, cnt decrements.
  - BUSY with cnt==0: mem_stall=0 (completing cycle), go to IDLE.
  - IDLE with no pending access, or WAIT_STATES==0: mem_stall=0; that cycle is the completing cycle.
- Completing edge:
  - A store commits data2 to memory exactly once.
  - MEM/WB captures wr_con, rd, alu_res, and the read data.
  - read_data is the memory word on loads and 0 otherwise.
- Stalled edge: MEM/WB loads a bubble (wr_con=00, rd=0, data=0), so write-back never sees a duplicate.
- read and write both set: the load returns the pre-store word and the store commits.
- Misalignment (alu_res[1:0]!=0 on an access):
  - The store is suppressed.
  - Load data is 0.
  - mis_align sets and stays set until reset.
  - Access timing is unchanged.

## Timing
- Load/store latency: WAIT_STATES+1 cycles in MEM; mem_stall is high for exactly WAIT_STATES consecutive cycles.
- Non-access instructions: 1 cycle, no stall.
- Back-to-back accesses:
  - The next access begins in IDLE on the cycle after completion.
  - No idle gap is required.
- Reset values: FSM=IDLE, cnt=0, all mem_wb_* = 0, mis_align=0.
- mem_stall is 0 during reset; pc_src follows its inputs.
- Reset mid-access:
  - The pending store is not committed.
  - The FSM returns to IDLE.
- Memory contents are not reset.

## Structure
- Shared package mips_pkg:
  - mem_con bit indices (MC_BRANCH=2, MC_READ=1, MC_WRITE=0).
  - wr_con bit indices (WC_REGWRITE=1, WC_MEMTOREG=0).
  - FSM state encoding.
- Sub-module data_mem:
  - 2**ADDR_W x 32 array.
  - Asynchronous read.
  - Synchronous write enabled by a single we pulse from mem_stage.
- mem_stage holds the FSM, counter, branch logic, misalignment check and MEM/WB registers.

## Test plan
- WAIT_STATES=2, SW data2=0xDEADBEEF at alu_res=0x10 → mem_stall high for 2 cycles; word 4 written once; MEM/WB shows 2 bubbles, then wr_con=00.
- Then LW at alu_res=0x10 with wr_con=11, rd=8 → 3 cycles later mem_wb_read_data=0xDEADBEEF, mem_wb_rd=8, wr_con=11.
- Branch with zero=1, pc_4_off=0x40 → pc_src=1, branch_target=0x40 in the same cycle; mem_stall=0.
- LW at alu_res=0x13 → mis_align=1 and read_data=0, with normal latency; a following aligned LW works and mis_align stays 1.
- rst_n low during the second stall cycle of a SW to word 5 → word 5 is unchanged, outputs are 0, and the FSM is in IDLE.
- WAIT_STATES=0, alternating LW/SW/ALU ops → mem_stall never asserts; one result per cycle.
